sub_share_arb: RTL
==================

Name: sub_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 10-bit ripple-borrow subtractor (inverted-b plus carry-in 1; 11-bit diff, bit 10 tied 0) among NREQ requesters.
- Each requester has its own valid/ready request channel. A single response channel returns the difference, a borrow flag and the winner's ID.
- Sits between ALU issue ports and the shared subtract resource. At most one operation is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..4).
- IDW, 2, width of rsp_id; NREQ <= 2**IDW.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*10  flattened minuends; requester i at bits [10*i+9:10*i].
- req_b  input  NREQ*10  flattened subtrahends; same packing as req_a.
- req_ready  output  NREQ  one-hot accept strobe, combinational.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_diff  output  11  a-b modulo 1024 in [9:0]; [10] always 0.
- rsp_borrow  output  1  1 when a < b (unsigned).
- rsp_id  output  IDW  index of the requester that produced the result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, rr_ptr=0, operand/ID registers=0, rsp_valid=0, rsp_diff=0, rsp_borrow=0, rsp_id=0, busy=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is one-hot on the first requester with req_valid=1, searching from rr_ptr upward and wrapping at NREQ-1 to 0. req_ready=0 if no requester is valid.
  - On an edge with a grant: latch that requester's a, b and index into op_a, op_b, op_id; rr_ptr <= (granted+1) mod NREQ; go to EXEC.
- EXEC:
  - The subtractor input is op_a, op_b. On the edge: rsp_diff <= diff, rsp_borrow <= (op_a < op_b), rsp_id <= op_id, rsp_valid <= 1; go to RESP.
  - Equivalently, rsp_borrow is the inverted carry-out of the subtractor's bit-9 adder.
- RESP:
  - rsp_* are held stable while rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid <= 0; go to IDLE. rsp_diff, rsp_borrow and rsp_id keep their last values.
- req_ready is 0 for all requesters in EXEC and RESP.
- Latency: the accept edge is E; rsp_valid rises at E+1. The next accept is possible at the edge after the response handshake. Peak throughput is 1 op per 3 cycles.
- Requesters hold req_valid and operands stable until they see req_ready. Dropping valid before the grant is legal; the arbiter re-evaluates every IDLE cycle.
- rr_ptr advances only on a grant. A requester held valid is served within NREQ grants (starvation-free).
- Arithmetic: result is modulo 2^10. Wrap-around cases are a=0,b=1 -> 1023 with borrow 1, and a=b -> 0 with borrow 0.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response. rsp_valid drops immediately (asynchronous) and rr_ptr returns to 0.
- req_valid asserted in the same cycle as rsp_ready in RESP: not granted that cycle; granted in the following IDLE cycle.

Test Plan:
- Single op: req 0 valid, a=100, b=30, rsp_ready=1 -> req_ready=0001 in the accept cycle; one cycle later rsp_valid=1, rsp_diff=70, rsp_borrow=0, rsp_id=0; busy high for 2 cycles.
- Borrow/wrap:
  - a=5, b=9 -> rsp_diff=1020, borrow=1.
  - a=0, b=1023 -> diff=1, borrow=1.
  - a=1023, b=0 -> diff=1023, borrow=0.
  - a=b=512 -> diff=0, borrow=0.
  - rsp_diff[10]=0 in every case.
- Round-robin: all four req_valid held high, each with distinct operands, rsp_ready=1 -> grants in order 0,1,2,3,0,1; rsp_id matches; each requester's own diff is returned.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid while req 2 is valid -> rsp outputs stable, req_ready=0000 throughout; when rsp_ready=1, req 2 is granted the next cycle.
- Reset mid-op: assert rst during EXEC of req 1 -> rsp_valid=0 and busy=0 immediately, no response for req 1. After release, with reqs 0 and 2 valid -> grant 0 first (rr_ptr=0).
- Valid withdrawal: req 3 pulses valid for one cycle while the block is in RESP -> never granted, no response with rsp_id=3.

Source files
------------

// File: rtl/sub_share_arb.sv
// sub_share_arb: round-robin arbiter that time-shares one 10-bit ripple-borrow
// subtractor among NREQ requesters. One operation is in flight at a time.
// Each operation takes an accept cycle, an execute cycle and a response
// cycle that is held until the consumer takes it.
//
//   state | meaning
//   IDLE  | waiting for any requester; grant goes to the first valid one from rr_ptr
//   EXEC  | latched operands drive the shared subtractor; result captured on the edge
//   RESP  | result presented on rsp_*; held until rsp_ready
module sub_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*10-1:0] req_a,
  input  logic [NREQ*10-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [10:0]       rsp_diff,
  output logic              rsp_borrow,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [9:0]      op_a_q, op_a_d;
  logic [9:0]      op_b_q, op_b_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [10:0]     rsp_diff_q, rsp_diff_d;
  logic            rsp_borrow_q, rsp_borrow_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;

  // ---------------------------------------------------------------------------
  // Shared subtractor: a + ~b + 1, one full adder per bit so the borrow ripples.
  // The carry out of bit 9 is high exactly when no borrow occurred (a >= b).
  // ---------------------------------------------------------------------------
  logic [9:0]  sub_b_inv;
  logic [10:0] sub_carry;
  logic [9:0]  sub_sum;
  logic [10:0] sub_diff;
  logic        sub_borrow;

  assign sub_b_inv    = ~op_b_q;
  assign sub_carry[0] = 1'b1;

  for (genvar g = 0; g < 10; g++) begin : g_sub_bit
    assign sub_sum[g]     = op_a_q[g] ^ sub_b_inv[g] ^ sub_carry[g];
    assign sub_carry[g+1] = (op_a_q[g] & sub_b_inv[g]) |
                            (op_a_q[g] & sub_carry[g]) |
                            (sub_b_inv[g] & sub_carry[g]);
  end

  assign sub_diff   = {1'b0, sub_sum};
  assign sub_borrow = ~sub_carry[10];

  // ---------------------------------------------------------------------------
  // Round-robin pick: prefer the lowest valid index at or above rr_ptr,
  // otherwise wrap to the lowest valid index overall.
  // ---------------------------------------------------------------------------
  logic           hi_found, lo_found, grant_found;
  logic [IDW-1:0] hi_idx, lo_idx, grant_idx;

  // Priority search; the loop runs downward so the lowest index wins.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        if (IDW'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    grant_found = lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  // One-hot accept strobe, only offered while the subtractor is free.
  always_comb begin
    req_ready = '0;
    if ((state_q == ST_IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state and datapath register updates.
  // ---------------------------------------------------------------------------
  // Next-state logic for the FSM and every register it owns.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_diff_d   = rsp_diff_q;
    rsp_borrow_d = rsp_borrow_q;
    rsp_id_d     = rsp_id_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          op_a_d   = req_a[10*grant_idx +: 10];
          op_b_d   = req_b[10*grant_idx +: 10];
          op_id_d  = grant_idx;
          rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_diff_d   = sub_diff;
        rsp_borrow_d = sub_borrow;
        rsp_id_d     = op_id_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        // Result fields keep their last value after the handshake.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath flops; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_diff_q   <= '0;
      rsp_borrow_q <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_diff_q   <= rsp_diff_d;
      rsp_borrow_q <= rsp_borrow_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_diff   = rsp_diff_q;
  assign rsp_borrow = rsp_borrow_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
